// File: rtl/run_burst_tx.sv
// Run-length burst transmitter: drives d high for cmd_len cycles, then low for GAP cycles.
// Optional ALARM_MODEL_EN adds exp_alarm, a model of the downstream consecutive-ones detector.
module run_burst_tx #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             d,
  output logic             busy,
`ifdef ALARM_MODEL_EN
  output logic             done,
  output logic             exp_alarm
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  localparam logic [3:0] GapInit = 4'(GAP);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             zero_done_q, zero_done_d;
  logic             xfer;

  assign xfer = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    zero_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          // A zero-length command completes without leaving IDLE.
          if (cmd_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            run_cnt_d = cmd_len;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        run_cnt_d = run_cnt_q - LEN_W'(1);
        if (run_cnt_q == LEN_W'(1)) begin
          gap_cnt_d = GapInit;
          state_d   = StGap;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q == 4'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      run_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      zero_done_q <= zero_done_d;
    end
  end

  // All outputs are decodes of registered state; no input reaches them combinationally.
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign d         = (state_q == StRun);
  assign done      = zero_done_q || ((state_q == StGap) && (gap_cnt_q == 4'd1));

`ifdef ALARM_MODEL_EN
  logic [1:0] ones_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_q <= 2'd0;
    end else if (d) begin
      ones_q <= (ones_q == 2'd3) ? 2'd3 : ones_q + 2'd1;
    end else begin
      ones_q <= 2'd0;
    end
  end

  assign exp_alarm = ones_q[1];
`endif

endmodule
